// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider state encoding, default operand widths and
// the divide opcode held in reserve for the ALU decoder.
package alu_pkg;

   localparam int DW_DEF = 16;
   localparam int VW_DEF = 8;

   localparam logic [3:0] OP_DIV = 4'd5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } div_state_t;

endpackage : alu_pkg

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
   parameter int VW = alu_pkg::VW_DEF
) (
   input  logic [VW-1:0] r_i,
   input  logic          bit_i,
   input  logic [VW-1:0] divisor_i,
   output logic [VW-1:0] r_o,
   output logic          q_o
);

   logic [VW:0] r_shift;

   always_comb begin
      r_shift = {r_i, bit_i};
      q_o     = (r_shift >= {1'b0, divisor_i});
      // The result is below the divisor, so the low VW bits of the
      // subtraction are exact and the carry-out bit is never needed.
      r_o     = q_o ? (r_shift[VW-1:0] - divisor_i) : r_shift[VW-1:0];
   end

endmodule : div_step

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider producing one quotient bit per clock;
// divide-by-zero short-circuits straight to the result cycle.
module seq_divider
   import alu_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int VW = VW_DEF,
   parameter int CW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          dbz,
   output logic          busy,
   output logic          done
);

   div_state_t    state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [VW-1:0] r_q, r_d;
   logic [DW-1:0] q_q, q_d;
   logic [VW-1:0] divisor_q, divisor_d;
   logic [DW-1:0] quotient_q, quotient_d;
   logic [VW-1:0] remainder_q, remainder_d;
   logic          dbz_q, dbz_d;

   logic [VW-1:0] step_r;
   logic          step_q;

   div_step #(.VW(VW)) u_step (
      .r_i       (r_q),
      .bit_i     (q_q[DW-1]),
      .divisor_i (divisor_q),
      .r_o       (step_r),
      .q_o       (step_q)
   );

   always_comb begin
      // NOTE: every always_comb target gets a default first so no path can infer a latch.
      state_d     = state_q;
      count_d     = count_q;
      r_d         = r_q;
      q_d         = q_q;
      divisor_d   = divisor_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               divisor_d = divisor;
               if (divisor != '0) begin
                  state_d = S_RUN;
                  count_d = CW'(DW - 1);
                  r_d     = '0;
                  q_d     = dividend;
               end else begin
                  state_d     = S_DONE;
                  quotient_d  = '1;
                  remainder_d = dividend[VW-1:0];
                  dbz_d       = 1'b1;
               end
            end
         end
         S_RUN: begin
            r_d = step_r;
            q_d = {q_q[DW-2:0], step_q};
            if (count_q == '0) begin
               state_d     = S_DONE;
               quotient_d  = {q_q[DW-2:0], step_q};
               remainder_d = step_r;
               dbz_d       = 1'b0;
            end else begin
               count_d = count_q - 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         count_q     <= '0;
         r_q         <= '0;
         q_q         <= '0;
         divisor_q   <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         r_q         <= r_d;
         q_q         <= q_d;
         divisor_q   <= divisor_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
      end
   end

   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign dbz       = dbz_q;
   assign busy      = (state_q == S_RUN);
   assign done      = (state_q == S_DONE);

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider: values, latency, divide-by-zero,
// ignored restarts, asynchronous abort and back-to-back throughput.
module tb_seq_divider;

   localparam int DW = 16;
   localparam int VW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [DW-1:0] dividend = '0;
   logic [VW-1:0] divisor = '0;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          dbz;
   logic          busy;
   logic          done;

   int n_vec = 0;
   int n_miscmp = 0;

   seq_divider #(.DW(DW), .VW(VW), .CW(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .quotient  (quotient),
      .remainder (remainder),
      .dbz       (dbz),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Present operands at a falling edge, let the rising edge accept them.
   task automatic issue(input logic [DW-1:0] dd, input logic [VW-1:0] dv);
      @(negedge clk);
      dividend = dd;
      divisor  = dv;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Count rising edges after the start edge until done is seen (bounded).
   task automatic wait_done(output int lat);
      lat = 0;
      while (!done && lat < 40) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_vec++;
      if ({quotient, remainder, dbz, busy, done} !== '0) begin
         n_miscmp++;
         $display("FAIL reset_outputs: got q=%h r=%h dbz=%b busy=%b done=%b, want all 0",
                  quotient, remainder, dbz, busy, done);
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_divide();
      logic [DW-1:0] t_dd [6] = '{16'd2556, 16'd2560, 16'd7, 16'hFFFF, 16'hFFFF, 16'd1000};
      logic [VW-1:0] t_dv [6] = '{8'd18,    8'd18,    8'd9, 8'd1,     8'hFF,    8'd7};
      logic [DW-1:0] t_q  [6] = '{16'h008E, 16'd142,  16'd0, 16'hFFFF, 16'h0101, 16'd142};
      logic [VW-1:0] t_r  [6] = '{8'd0,     8'd4,     8'd7, 8'd0,     8'd0,     8'd6};
      int lat;
      for (int i = 0; i < 6; i++) begin
         issue(t_dd[i], t_dv[i]);
         n_vec++;
         if (busy !== 1'b1) begin
            n_miscmp++;
            $display("FAIL div%0d_busy: got %b, want 1", i, busy);
         end
         dividend = ~t_dd[i];
         divisor  = ~t_dv[i];
         wait_done(lat);
         n_vec++;
         if (lat !== DW) begin
            n_miscmp++;
            $display("FAIL div%0d_latency: got %0d edges, want %0d", i, lat, DW);
         end
         n_vec++;
         if ({quotient, remainder, dbz, busy} !== {t_q[i], t_r[i], 1'b0, 1'b0}) begin
            n_miscmp++;
            $display("FAIL div%0d_result: got q=%h r=%h dbz=%b busy=%b, want q=%h r=%h dbz=0 busy=0",
                     i, quotient, remainder, dbz, busy, t_q[i], t_r[i]);
         end
         @(posedge clk);
         #1;
         n_vec++;
         if ({done, quotient, remainder} !== {1'b0, t_q[i], t_r[i]}) begin
            n_miscmp++;
            $display("FAIL div%0d_hold: got done=%b q=%h r=%h, want done=0 q=%h r=%h",
                     i, done, quotient, remainder, t_q[i], t_r[i]);
         end
      end
   endtask

   task automatic test_dbz();
      int lat;
      issue(16'd100, 8'd0);
      wait_done(lat);
      n_vec++;
      if (lat !== 0) begin
         n_miscmp++;
         $display("FAIL dbz_latency: got %0d edges, want 0", lat);
      end
      n_vec++;
      if ({quotient, remainder, dbz, busy} !== {16'hFFFF, 8'd100, 1'b1, 1'b0}) begin
         n_miscmp++;
         $display("FAIL dbz_result: got q=%h r=%h dbz=%b busy=%b, want q=ffff r=64 dbz=1 busy=0",
                  quotient, remainder, dbz, busy);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if ({busy, done, dbz} !== 3'b001) begin
         n_miscmp++;
         $display("FAIL dbz_after: got busy=%b done=%b dbz=%b, want busy=0 done=0 dbz=1",
                  busy, done, dbz);
      end
   endtask

   task automatic test_ignore_start();
      int lat;
      issue(16'd2556, 8'd18);
      repeat (3) @(posedge clk);
      @(negedge clk);
      dividend = 16'd5;
      divisor  = 8'd1;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      dividend = 16'h1234;
      divisor  = 8'd3;
      n_vec++;
      if (busy !== 1'b1) begin
         n_miscmp++;
         $display("FAIL ignore_busy: got %b, want 1", busy);
      end
      wait_done(lat);
      n_vec++;
      if (lat !== DW - 4) begin
         n_miscmp++;
         $display("FAIL ignore_latency: got %0d more edges, want %0d", lat, DW - 4);
      end
      n_vec++;
      if ({quotient, remainder, dbz} !== {16'd142, 8'd0, 1'b0}) begin
         n_miscmp++;
         $display("FAIL ignore_result: got q=%h r=%h dbz=%b, want q=008e r=00 dbz=0",
                  quotient, remainder, dbz);
      end
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      int lat;
      logic seen_done;
      issue(16'd2556, 8'd18);
      repeat (5) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      n_vec++;
      if ({quotient, remainder, dbz, busy, done} !== '0) begin
         n_miscmp++;
         $display("FAIL abort_outputs: got q=%h r=%h dbz=%b busy=%b done=%b, want all 0",
                  quotient, remainder, dbz, busy, done);
      end
      @(posedge clk);
      #3 rst = 1'b1;
      seen_done = 1'b0;
      repeat (20) begin
         @(posedge clk);
         #1 seen_done |= done;
      end
      n_vec++;
      if (seen_done !== 1'b0) begin
         n_miscmp++;
         $display("FAIL abort_no_done: got done pulse=%b, want 0", seen_done);
      end
      issue(16'd2560, 8'd18);
      wait_done(lat);
      n_vec++;
      if ({lat == DW, quotient, remainder} !== {1'b1, 16'd142, 8'd4}) begin
         n_miscmp++;
         $display("FAIL abort_restart: got lat=%0d q=%h r=%h, want lat=%0d q=008e r=04",
                  lat, quotient, remainder, DW);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int lat;
      @(negedge clk);
      dividend = 16'd2560;
      divisor  = 8'd18;
      start    = 1'b1;
      @(posedge clk);
      #1;
      wait_done(lat);
      @(posedge clk);
      #1;
      wait_done(lat);
      start = 1'b0;
      n_vec++;
      if (lat !== DW + 1) begin
         n_miscmp++;
         $display("FAIL b2b_period: got %0d, want %0d", lat + 1, DW + 2);
      end
      n_vec++;
      if ({done, quotient, remainder} !== {1'b1, 16'd142, 8'd4}) begin
         n_miscmp++;
         $display("FAIL b2b_result: got done=%b q=%h r=%h, want done=1 q=008e r=04",
                  done, quotient, remainder);
      end
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if ({busy, done} !== 2'b00) begin
         n_miscmp++;
         $display("FAIL b2b_idle: got busy=%b done=%b, want 0 0", busy, done);
      end
   endtask

   initial begin
      test_reset();
      test_divide();
      test_dbz();
      test_ignore_start();
      test_async_reset();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule : tb_seq_divider

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle restoring divider, the inverse of the ALU's shift-add multiplier.
- Divides the 16-bit product-width operand by an 8-bit operand, one quotient bit per clock.
- Produces a 16-bit quotient, an 8-bit remainder and a divide-by-zero flag.
- Sits beside the multiplier as the planned divide opcode backend, sharing the ALU's clk/rst.

Parameters:
- DW, 16, dividend and quotient width.
- VW, 8, divisor and remainder width.
- CW, 5, iteration counter width (must satisfy 2^CW > DW).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- dividend  input  DW  numerator, captured on the accepted start edge.
- divisor  input  VW  denominator, captured on the accepted start edge.
- quotient  output  DW  result, registered.
- remainder  output  VW  result, registered.
- dbz  output  1  divide-by-zero flag, registered.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse when results are valid.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; quotient=0, remainder=0, dbz=0, busy=0, done=0; counter and working registers cleared.
- Reset is honoured at any time; a division in progress is aborted with no done pulse.
- States:
  - IDLE: start=1 at a rising edge captures dividend/divisor. If divisor!=0, go to RUN, set busy=1, count=DW-1, partial remainder R(VW+1 bits)=0, Q shift register=dividend. If divisor==0, go to DONE.
  - RUN: each edge performs R' = {R[VW-1:0], Q[DW-1]}; Q shifts left by one. If R' >= {1'b0,divisor}, R = R' - divisor and Q[0]=1; otherwise R = R' and Q[0]=0. When count==0, go to DONE; otherwise decrement count.
  - DONE: lasts one cycle. done=1 and busy=0; then return to IDLE.
- Output registers update on the edge entering DONE and hold until the next completion or reset.
- Normal completion: quotient=Q, remainder=R[VW-1:0], dbz=0.
- Divide-by-zero: quotient=all ones (16'hFFFF), remainder=dividend[VW-1:0], dbz=1. Result is ready 1 cycle after start (no RUN state).
- Latency, normal case: start accepted at edge N; RUN occupies edges N+1..N+DW; done is high in the cycle after edge N+DW (17 cycles after start). Back-to-back throughput is one result per DW+2 cycles.
- start while busy=1 or in DONE is ignored: no queueing, operands not recaptured.
- Operand inputs may change freely after the start edge; results depend only on the captured values.
- start held high continuously re-triggers from IDLE every DW+2 cycles.
- Arithmetic is unsigned. The partial remainder stays below divisor after every step, so VW+1 bits suffice with no overflow. No quotient overflow is possible (DW-bit quotient, VW-bit divisor >= 1).

Decomposition:
- Shared package alu_pkg:
  - state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - DW/VW defaults;
  - opcode constant for divide, reserved for the ALU's future expansion.
- Sub-module div_step: combinational single restoring step.
  - Inputs: R, next dividend bit, divisor.
  - Outputs: new R and quotient bit.
  - Instantiated once in seq_divider; unit-testable on its own.

Test Plan:
- dividend=16'd2556 (0x09FC), divisor=8'd18 -> after 17 cycles done=1; quotient=16'h008E, remainder=0, dbz=0 (round-trips the multiplier's 0x8E*0x12 result).
- dividend=16'd2560, divisor=18 -> quotient=142, remainder=4; dividend=7, divisor=9 -> quotient=0, remainder=7.
- dividend=16'hFFFF, divisor=1 -> quotient=16'hFFFF, remainder=0; dividend=16'hFFFF, divisor=8'hFF -> quotient=16'h0101, remainder=0.
- dividend=100, divisor=0 -> done one cycle after start; dbz=1, quotient=16'hFFFF, remainder=8'd100; busy never asserts.
- Start 2556/18, pulse start with 5/1 at cycle 5, and change the operand inputs mid-run -> second start ignored; result remains 142 r 0 from the captured operands.
- Start a division, drive rst=0 for one cycle mid-RUN (asynchronously, between edges) -> all outputs 0 immediately, no done pulse; a fresh start 2560/18 then completes normally with 142 r 4.
